buzz_sched: RTL and testbench
=============================

# buzz_sched

Buzzer scheduler for the key-matrix display board: one piezo buzzer is shared between three requesters, and each requester gets its own beep pattern. The block latches one-cycle request pulses, grants the buzzer by fixed priority, and sequences ON/OFF/GAP phases timed on the board's 1 kHz tick. Its `buzz` output drives the buzzer pin directly and replaces the single-source keyclick extender in the top level.

## Interface
- `CW`, 8: width of the ms phase counter; every `*_MS` value must be ≤ 2^CW−1.
- `CLICK_MS`, 30: ON length for requester 0 (key click).
- `ERR_ON_MS`, 50: ON length per beep for requester 1 (error).
- `ERR_OFF_MS`, 50: OFF length between error beeps.
- `ERR_REPS`, 3: number of error beeps, range 1..3.
- `LONG_MS`, 200: ON length for requester 2 (clear/confirm).
- `GAP_MS`, 20: silent gap after every pattern.

Ports (reset rst, asynchronous, active-low; clock clk):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active-low
- `tick1k`  in  1  one-clk pulse every 1 ms
- `req`  in  3  one-clk request pulses; index 2 = highest priority
- `mute`  in  1  level; silences the buzzer and flushes all requests
- `buzz`  out  1  buzzer drive, registered
- `grant`  out  3  one-hot active requester; 0 when IDLE or GAP
- `busy`  out  1  state ≠ IDLE

## Operation
- Pending register `pend[2:0]`:
  - Set by `req[i]` the cycle after the pulse.
  - Cleared when requester i is granted.
- States:
  - **IDLE**: if `pend` ≠ 0, grant the highest set index and go to ON. Otherwise stay.
  - **ON**: buzzer sounds for the active length (`CLICK_MS`, `ERR_ON_MS` or `LONG_MS`). When the length expires:
    - error pattern with beeps remaining → OFF;
    - otherwise → GAP.
  - **OFF**: lasts `ERR_OFF_MS`, then → ON and the beep count increments.
  - **GAP**: lasts `GAP_MS`, then → IDLE with `grant` = 0.
- No preemption. A higher-priority request arriving during a pattern stays pending and is served after GAP.
- Re-request from the active requester while it is in ON/OFF:
  - restarts its pattern: counter = 0, beep count = 0, state ON;
  - its pend bit is not set.
- Requests during GAP are latched normally.
- `req[i]` in the same cycle as pend[i] is cleared by its grant: treated as a restart on the next cycle.
- `mute` = 1:
  - next cycle: state IDLE, `pend` = 0, counters 0, `buzz` = 0, `grant` = 0;
  - `req` is ignored while muted.

## Timing
- Reset values: `buzz` = 0, `grant` = 0, `busy` = 0, `pend` = 0, state IDLE, counters 0.
- Request latency:
  - `req` at cycle n → pend at n+1;
  - if IDLE, then at n+2 state = ON, `grant`/`busy` valid and `buzz` = 1.
- `buzz` is registered and equals (next state == ON). It is never combinational from `req`.
- Phase timer:
  - cleared on every phase entry;
  - increments on `tick1k`;
  - the phase ends on the tick where count == LEN−1;
  - a phase therefore lasts between LEN−1 and LEN ms. LEN = 0 is not supported.
- Counter arithmetic: unsigned, CW bits, no wrap. The compare stops it first.
- The beep counter is 2 bits.
- `tick1k` while a phase is being entered counts toward the new phase only after entry; the entry cycle's tick is ignored.
- Reset asserted mid-pattern: all state clears immediately (asynchronous) and `buzz` drops without waiting for a clock.

## Structure
- Shared package `buzz_pkg` holds:
  - state enum IDLE/ON/OFF/GAP;
  - requester index constants REQ_CLICK = 0, REQ_ERR = 1, REQ_LONG = 2;
  - default `*_MS` constants, reused by the top-level instantiation.
- One sub-module, `buzz_ms_cnt`: CW-bit tick counter with `clr`, `tick`, `len` inputs and a `done` output.
- Pend logic, arbiter and FSM stay in `buzz_sched`.

## Test plan
In simulation `tick1k` is driven every 10 clk.
- **Single click:** `req` = 001 at cycle 5 → `buzz` = 1 and `grant` = 001 at cycle 7; `buzz` falls after 29–30 ticks; `busy` stays 1 for a further 19–20 ticks, then drops.
- **Error pattern:** `req` = 010 → three `buzz` pulses, each 49–50 ticks, separated by 49–50-tick gaps, then a 20-tick GAP → IDLE.
- **Simultaneous requests:** `req` = 111 in one cycle → LONG served first (200 ms), then ERR, then CLICK, each separated by a GAP; `grant` sequence 100, 010, 001.
- **Restart and no-preemption:**
  - `req[0]` re-pulsed 10 ticks into a click → ON restarts, total `buzz` ≈ 40 ticks.
  - `req[2]` pulsed during a click → click completes, then LONG follows the GAP.
- **Mute:** `mute` asserted 3 ticks into LONG with CLICK pending → `buzz` = 0 next cycle, `pend` = 0; after `mute` falls, nothing sounds without a new `req`.
- **Reset mid-pattern:** `rst` = 0 mid-OFF of the error pattern → all outputs 0 asynchronously; after release, a new `req[0]` behaves exactly as in the single-click case.

Source files
------------

// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer scheduler: FSM states, requester indices,
// default pattern timings and small arbitration helpers.
package buzz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int REQ_CLICK = 0;
  localparam int REQ_ERR   = 1;
  localparam int REQ_LONG  = 2;

  localparam int CW_DEF         = 8;
  localparam int CLICK_MS_DEF   = 30;
  localparam int ERR_ON_MS_DEF  = 50;
  localparam int ERR_OFF_MS_DEF = 50;
  localparam int ERR_REPS_DEF   = 3;
  localparam int LONG_MS_DEF    = 200;
  localparam int GAP_MS_DEF     = 20;

  // Fixed priority: the highest requester index wins.
  function automatic logic [1:0] pick_hi(input logic [2:0] p);
    if (p[REQ_LONG])     return 2'(REQ_LONG);
    else if (p[REQ_ERR]) return 2'(REQ_ERR);
    else                 return 2'(REQ_CLICK);
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/buzz_ms_cnt.sv
// Millisecond phase timer: counts tick pulses from a cleared start and flags
// the tick on which the phase of length len ends.
module buzz_ms_cnt import buzz_pkg::*; #(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] len,
  output logic          done
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt;

  assign done = tick && (cnt == len - ONE);

  // The terminal compare halts the count, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (tick && !done) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/buzz_sched.sv
// Buzzer scheduler: latches request pulses, grants the shared piezo by fixed
// priority and sequences ON/OFF/GAP phases on the 1 kHz tick.
module buzz_sched import buzz_pkg::*; #(
  parameter int CW         = CW_DEF,
  parameter int CLICK_MS   = CLICK_MS_DEF,
  parameter int ERR_ON_MS  = ERR_ON_MS_DEF,
  parameter int ERR_OFF_MS = ERR_OFF_MS_DEF,
  parameter int ERR_REPS   = ERR_REPS_DEF,
  parameter int LONG_MS    = LONG_MS_DEF,
  parameter int GAP_MS     = GAP_MS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick1k,
  input  logic [2:0] req,
  input  logic       mute,
  output logic       buzz,
  output logic [2:0] grant,
  output logic       busy
);

  localparam logic [1:0] LAST_BEEP = 2'(ERR_REPS - 1);

  state_t        state, state_d;
  logic [2:0]    pend, pend_d;
  logic [1:0]    act, act_d;
  logic [1:0]    beep, beep_d;
  logic          restart_q, restart_d;
  logic          restart;
  logic          clr;
  logic          done;
  logic [2:0]    gnt_clr;
  logic [2:0]    act_mask;
  logic [CW-1:0] len;

  buzz_ms_cnt #(.CW(CW)) u_ms_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick1k),
    .len  (len),
    .done (done)
  );

  assign act_mask = (state == ON || state == OFF) ? onehot(act) : 3'b000;
  // A pulse landing on the grant cycle is replayed as a restart one cycle later.
  assign restart  = !mute && (((req & act_mask) != 3'b000) || restart_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend      <= '0;
      act       <= '0;
      beep      <= '0;
      restart_q <= 1'b0;
      buzz      <= 1'b0;
    end else begin
      state     <= state_d;
      pend      <= pend_d;
      act       <= act_d;
      beep      <= beep_d;
      restart_q <= restart_d;
      buzz      <= (state_d == ON);
    end
  end

  always_comb begin
    state_d = state;
    act_d   = act;
    beep_d  = beep;
    clr     = 1'b0;
    gnt_clr = '0;
    if (mute) begin
      state_d = IDLE;
      beep_d  = '0;
      clr     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          clr    = 1'b1;
          beep_d = '0;
          if (pend != 3'b000) begin
            state_d = ON;
            act_d   = pick_hi(pend);
            gnt_clr = onehot(act_d);
          end
        end
        ON: begin
          if (restart) begin
            clr    = 1'b1;
            beep_d = '0;
          end else if (done) begin
            clr     = 1'b1;
            state_d = (act == 2'(REQ_ERR) && beep < LAST_BEEP) ? OFF : GAP;
          end
        end
        OFF: begin
          if (restart) begin
            state_d = ON;
            clr     = 1'b1;
            beep_d  = '0;
          end else if (done) begin
            state_d = ON;
            clr     = 1'b1;
            beep_d  = beep + 2'd1;
          end
        end
        GAP: begin
          if (done) begin
            state_d = IDLE;
            clr     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // The active requester's own pulses restart it rather than queueing.
    pend_d    = mute ? 3'b000 : ((pend & ~gnt_clr) | (req & ~act_mask & ~gnt_clr));
    restart_d = !mute && ((req & gnt_clr) != 3'b000);
  end

  always_comb begin
    busy  = (state != IDLE);
    grant = act_mask;
    case (state)
      ON: begin
        if (act == 2'(REQ_LONG))     len = CW'(LONG_MS);
        else if (act == 2'(REQ_ERR)) len = CW'(ERR_ON_MS);
        else                         len = CW'(CLICK_MS);
      end
      OFF:     len = CW'(ERR_OFF_MS);
      default: len = CW'(GAP_MS);
    endcase
  end

endmodule

// File: tb/tb_buzz_sched.sv
// Directed bench for buzz_sched: tick1k every 10 clk, phase lengths checked
// as clock-cycle windows of (LEN-1)*10+1 .. LEN*10.
module tb_buzz_sched;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       tick1k = 1'b0;
  logic       mute   = 1'b0;
  logic [2:0] req    = 3'b000;
  logic       buzz;
  logic       busy;
  logic [2:0] grant;

  int passed = 0;
  int total  = 0;

  buzz_sched dut (
    .clk    (clk),
    .rst    (rst),
    .tick1k (tick1k),
    .req    (req),
    .mute   (mute),
    .buzz   (buzz),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tick1k = (tc == 9);
      tc = (tc == 9) ? 0 : tc + 1;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic check_rng(input string tag, input int n, input int lo, input int hi);
    total++;
    assert (n >= lo && n <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, n, lo, hi);
  endtask

  // Cycles until buzz (or busy) reaches val; budget+1 on timeout.
  task automatic wait_for(input bit use_busy, input logic val, input int budget, output int n);
    n = 0;
    while (((use_busy ? busy : buzz) !== val) && n <= budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic on_phase(input string tag, input int lo, input int hi);
    int n;
    wait_for(1'b0, 1'b0, hi + 100, n);
    check_rng(tag, n, lo, hi);
  endtask

  task automatic gap_phase(input string tag);
    int n;
    check({tag, "_grant0"}, grant, 3'b000);
    wait_for(1'b1, 1'b0, 300, n);
    check_rng(tag, n, 191, 200);
  endtask

  task automatic err_beeps(input string tag);
    int n;
    for (int b = 0; b < 3; b++) begin
      on_phase({tag, "_on"}, 491, 500);
      if (b < 2) begin
        check({tag, "_off_grant"}, grant, 3'b010);
        wait_for(1'b0, 1'b1, 600, n);
        check_rng({tag, "_off"}, n, 491, 500);
      end
    end
    gap_phase({tag, "_gap"});
  endtask

  task automatic single_click(input string tag);
    req = 3'b001;
    cyc();
    req = 3'b000;
    check({tag, "_pend"}, dut.pend, 3'b001);
    check({tag, "_buzz_n1"}, buzz, 1'b0);
    cyc();
    check({tag, "_buzz_n2"}, buzz, 1'b1);
    check({tag, "_grant"}, grant, 3'b001);
    check({tag, "_busy"}, busy, 1'b1);
    on_phase({tag, "_on"}, 291, 300);
    check({tag, "_busy_gap"}, busy, 1'b1);
    gap_phase({tag, "_gap"});
  endtask

  initial begin : main
    int n;
    int loud;

    // Reset state
    cyc(3);
    check("rst_buzz", buzz, 1'b0);
    check("rst_grant", grant, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_pend", dut.pend, 3'b000);
    rst = 1'b1;
    cyc(2);

    single_click("click");

    // Error pattern
    req = 3'b010;
    cyc();
    req = 3'b000;
    cyc();
    check("err_buzz", buzz, 1'b1);
    check("err_grant", grant, 3'b010);
    err_beeps("err");

    // Simultaneous requests served LONG, ERR, CLICK
    req = 3'b111;
    cyc();
    req = 3'b000;
    check("all_pend", dut.pend, 3'b111);
    cyc();
    check("all_g_long", grant, 3'b100);
    check("all_pend2", dut.pend, 3'b011);
    on_phase("all_long_on", 1991, 2000);
    gap_phase("all_gap1");
    cyc();
    check("all_g_err", grant, 3'b010);
    check("all_buzz_err", buzz, 1'b1);
    err_beeps("all_err");
    cyc();
    check("all_g_click", grant, 3'b001);
    on_phase("all_click_on", 291, 300);
    gap_phase("all_gap3");

    // Restart by the active requester
    req = 3'b001;
    cyc();
    req = 3'b000;
    cyc();
    check("rs_buzz", buzz, 1'b1);
    cyc(100);
    req = 3'b001;
    cyc();
    req = 3'b000;
    check("rs_pend", dut.pend, 3'b000);
    check("rs_grant", grant, 3'b001);
    on_phase("rs_on", 291, 300);
    gap_phase("rs_gap");

    // No preemption: LONG waits for the click and its gap
    req = 3'b001;
    cyc();
    req = 3'b000;
    cyc();
    check("np_buzz", buzz, 1'b1);
    cyc(50);
    req = 3'b100;
    cyc();
    req = 3'b000;
    check("np_pend", dut.pend, 3'b100);
    check("np_grant", grant, 3'b001);
    on_phase("np_click_on", 240, 249);
    gap_phase("np_gap");
    cyc();
    check("np_g_long", grant, 3'b100);
    check("np_buzz_long", buzz, 1'b1);

    // Mute during LONG with CLICK pending
    cyc(5);
    req = 3'b001;
    cyc();
    req = 3'b000;
    check("mu_pend", dut.pend, 3'b001);
    cyc(24);
    mute = 1'b1;
    cyc();
    check("mu_buzz", buzz, 1'b0);
    check("mu_grant", grant, 3'b000);
    check("mu_busy", busy, 1'b0);
    check("mu_pend0", dut.pend, 3'b000);
    req = 3'b010;
    cyc();
    req = 3'b000;
    check("mu_req_ign", dut.pend, 3'b000);
    cyc(3);
    mute = 1'b0;
    loud = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (buzz || busy) loud++;
    end
    check("mu_silent", loud, 0);

    // Asynchronous reset in the middle of an error OFF phase
    req = 3'b010;
    cyc();
    req = 3'b000;
    cyc();
    check("ar_buzz", buzz, 1'b1);
    wait_for(1'b0, 1'b0, 600, n);
    check_rng("ar_on", n, 491, 500);
    check("ar_off_grant", grant, 3'b010);
    cyc(100);
    #2;
    rst = 1'b0;
    #1;
    check("ar_buzz0", buzz, 1'b0);
    check("ar_grant0", grant, 3'b000);
    check("ar_busy0", busy, 1'b0);
    check("ar_pend0", dut.pend, 3'b000);
    cyc(3);
    rst = 1'b1;
    cyc(2);
    single_click("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
